// File: rtl/flash_arbiter_if.sv
// flash_arbiter_if: requester-port and flash-engine signals shared by the arbiter and its environment
interface flash_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
);
  logic              p0_req, p0_write, p0_ack;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata, p0_rdata;
  logic              p1_req, p1_write, p1_ack;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata, p1_rdata;
  logic              err, grant, busy;
  logic              fl_en, fl_write, fl_done;
  logic [ADDR_W-1:0] fl_addr;
  logic [DATA_W-1:0] fl_wdata, fl_rdata;
  modport slave (
    input  p0_req, p0_write, p0_addr, p0_wdata, p1_req, p1_write, p1_addr, p1_wdata, fl_rdata, fl_done,
    output p0_ack, p0_rdata, p1_ack, p1_rdata, err, grant, busy, fl_en, fl_write, fl_addr, fl_wdata
  );
  modport master (
    output p0_req, p0_write, p0_addr, p0_wdata, p1_req, p1_write, p1_addr, p1_wdata, fl_rdata, fl_done,
    input  p0_ack, p0_rdata, p1_ack, p1_rdata, err, grant, busy, fl_en, fl_write, fl_addr, fl_wdata
  );
endinterface

// File: rtl/flash_arbiter.sv
// flash_arbiter: round-robin two-port sequencer sharing one flash word engine, with bounded BUSY wait
module flash_arbiter #(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 32,
  parameter int TO_W        = 20,
  parameter int TIMEOUT_CYC = 1000000
) (
  input logic             clk,
  input logic             reset,
  flash_arbiter_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [1:0]        r_state;
  logic              r_last_grant, r_grant, r_fl_en, r_fl_write, r_p0_ack, r_p1_ack, r_err, r_busy;
  logic [ADDR_W-1:0] r_fl_addr;
  logic [DATA_W-1:0] r_fl_wdata, r_p0_rdata, r_p1_rdata;
  logic [TO_W-1:0]   r_cnt;
  logic              w_any, w_pick, w_write, w_timeout;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  always_comb begin
    w_any     = bus.p0_req | bus.p1_req;
    w_pick    = (bus.p0_req & bus.p1_req) ? ~r_last_grant : bus.p1_req;
    w_write   = w_pick ? bus.p1_write : bus.p0_write;
    w_addr    = (w_pick ? bus.p1_addr : bus.p0_addr) & ~ADDR_W'(3);
    w_wdata   = w_pick ? bus.p1_wdata : bus.p0_wdata;
    w_timeout = r_cnt == TO_LAST;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_fl_en      <= 1'b0;
      r_fl_write   <= 1'b0;
      r_fl_addr    <= '0;
      r_fl_wdata   <= '0;
      r_p0_rdata   <= '0;
      r_p1_rdata   <= '0;
      r_p0_ack     <= 1'b0;
      r_p1_ack     <= 1'b0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_p0_ack <= 1'b0;
      r_p1_ack <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        IDLE: if (w_any) begin
          r_state      <= BUSY;
          r_busy       <= 1'b1;
          r_fl_en      <= 1'b1;
          r_grant      <= w_pick;
          r_last_grant <= w_pick;
          r_fl_write   <= w_write;
          r_fl_addr    <= w_addr;
          r_fl_wdata   <= w_wdata;
          r_cnt        <= '0;
        end
        // fl_done takes priority over a coincident timeout
        BUSY: if (bus.fl_done || w_timeout) begin
          r_state  <= RESP;
          r_fl_en  <= 1'b0;
          r_p0_ack <= ~r_grant;
          r_p1_ack <= r_grant;
          r_err    <= ~bus.fl_done;
          if (bus.fl_done && !r_fl_write && !r_grant) r_p0_rdata <= bus.fl_rdata;
          if (bus.fl_done && !r_fl_write && r_grant) r_p1_rdata <= bus.fl_rdata;
        end else begin
          r_cnt <= (&r_cnt) ? r_cnt : r_cnt + 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
  assign bus.p0_ack   = r_p0_ack;
  assign bus.p1_ack   = r_p1_ack;
  assign bus.p0_rdata = r_p0_rdata;
  assign bus.p1_rdata = r_p1_rdata;
  assign bus.err      = r_err;
  assign bus.grant    = r_grant;
  assign bus.busy     = r_busy;
  assign bus.fl_en    = r_fl_en;
  assign bus.fl_write = r_fl_write;
  assign bus.fl_addr  = r_fl_addr;
  assign bus.fl_wdata = r_fl_wdata;
endmodule
